// File: rtl/int_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package int_pkg;

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} int_state_t;

  localparam int MCAUSE_INT_BIT = 31;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder; index 0 has the highest priority.
module prio_enc #(
  parameter int N  = 16,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [CW-1:0] o_code,
  output logic          o_valid
);

  // Scan downwards so the lowest set index is the last assignment.
  always_comb begin
    o_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_code = CW'(i);
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/int_ctrl_v2.sv
// Machine-mode interrupt controller: latches sources into mip, raises a held trap
// request for the highest-priority enabled source and tracks handler occupancy.
module int_ctrl_v2
  import int_pkg::*;
#(
  parameter int                  NUM_IRQ   = 16,
  parameter logic [NUM_IRQ-1:0]  EDGE_MASK = '0,
  parameter int                  CODE_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] mie,
  input  logic               MIE,
  input  logic [31:0]        mtvec,
  input  logic               trap_ack,
  input  logic               mret,
  output logic               interrupt,
  output logic [CODE_W-1:0]  int_code,
  output logic [31:0]        pc_addr,
  output logic [31:0]        mcause_val,
  output logic [NUM_IRQ-1:0] mip,
  output logic               in_handler
);

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_mip;
  logic [CODE_W-1:0]  r_code;
  int_state_t         r_state;

  logic [NUM_IRQ-1:0] w_mip_d;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [CODE_W-1:0]  w_code;
  logic [CODE_W-1:0]  w_code_d;
  logic               w_valid;
  logic               w_ack;
  int_state_t         w_state_d;
  logic [31:0]        w_base;
  logic [31:0]        w_off;
  logic               w_unused_mtvec;

  assign w_elig = r_mip & mie;

  prio_enc #(
    .N  (NUM_IRQ),
    .CW (CODE_W)
  ) u_prio_enc (
    .i_req   (w_elig),
    .o_code  (w_code),
    .o_valid (w_valid)
  );

  // An acknowledge only counts while a request is actually outstanding.
  assign w_ack  = (r_state == REQ) && trap_ack;
  assign w_rise = r_irq_q & ~r_irq_prev;
  assign w_clr  = w_ack ? (NUM_IRQ'(1) << r_code) : '0;

  // Edge bits: a fresh rising edge wins over the acknowledge clear.
  assign w_mip_d = (EDGE_MASK & (w_rise | (r_mip & ~w_clr))) | (~EDGE_MASK & r_irq_q);

  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    unique case (r_state)
      IDLE: begin
        if (MIE && w_valid) begin
          w_state_d = REQ;
          w_code_d  = w_code;
        end
      end
      REQ:     if (trap_ack) w_state_d = HANDLER;
      HANDLER: if (mret) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_q    <= '0;
      r_irq_prev <= '0;
      r_mip      <= '0;
      r_code     <= '0;
      r_state    <= IDLE;
    end else begin
      r_irq_q    <= irq_i;
      r_irq_prev <= r_irq_q;
      r_mip      <= w_mip_d;
      r_code     <= w_code_d;
      r_state    <= w_state_d;
    end
  end

  assign w_base = {mtvec[31:2], 2'b00};
  assign w_off  = 32'(r_code) << 2;
  assign w_unused_mtvec = mtvec[1];

  assign pc_addr    = mtvec[0] ? (w_base + w_off) : w_base;
  assign interrupt  = (r_state == REQ);
  assign in_handler = (r_state == HANDLER);
  assign int_code   = r_code;
  assign mip        = r_mip;

  always_comb begin
    mcause_val                 = '0;
    mcause_val[MCAUSE_INT_BIT] = 1'b1;
    mcause_val[CODE_W-1:0]     = r_code;
  end

endmodule

// File: tb/tb_int_ctrl_v2.sv
// Scoreboard bench for int_ctrl_v2: stimulus pushes expected requests, a monitor checks them.
module tb_int_ctrl_v2;

  localparam int NI = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] irq_i;
  logic [NI-1:0] mie;
  logic          MIE;
  logic [31:0]   mtvec;
  logic          trap_ack;
  logic          mret;
  logic          interrupt;
  logic [CW-1:0] int_code;
  logic [31:0]   pc_addr;
  logic [31:0]   mcause_val;
  logic [NI-1:0] mip;
  logic          in_handler;

  int_ctrl_v2 #(
    .NUM_IRQ   (NI),
    .EDGE_MASK (16'h0004)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_i      (irq_i),
    .mie        (mie),
    .MIE        (MIE),
    .mtvec      (mtvec),
    .trap_ack   (trap_ack),
    .mret       (mret),
    .interrupt  (interrupt),
    .int_code   (int_code),
    .pc_addr    (pc_addr),
    .mcause_val (mcause_val),
    .mip        (mip),
    .in_handler (in_handler)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          code;
    logic [31:0] pc;
    logic [31:0] mc;
    int          cyc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising request is matched against the next scoreboard entry.
  bit            mon_en   = 1'b0;
  logic          prev_int = 1'b0;
  logic [CW-1:0] held     = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (interrupt === 1'b1 && prev_int !== 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_req", 32'(interrupt), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("req_code", 32'(int_code), 32'(e.code));
          check("req_pc", pc_addr, e.pc);
          check("req_mcause", mcause_val, e.mc);
          check("req_latency", 32'(cyc), 32'(e.cyc));
          held = int_code;
        end
      end else if (interrupt === 1'b1) begin
        check("code_frozen", 32'(int_code), 32'(held));
      end
      prev_int = interrupt;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_req(input int code, input logic [31:0] pc, input int lat);
    exp_t e;
    e.code = code;
    e.pc   = pc;
    e.mc   = 32'h8000_0000 | 32'(code);
    e.cyc  = cyc + lat;
    q.push_back(e);
  endtask

  task automatic wait_req();
    int n = 0;
    while (interrupt !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    check("req_seen", 32'(interrupt), 32'd1);
  endtask

  task automatic ack();
    trap_ack = 1'b1;
    step(1);
    trap_ack = 1'b0;
    check("ack_int_low", 32'(interrupt), 32'd0);
    check("ack_in_handler", 32'(in_handler), 32'd1);
  endtask

  task automatic do_mret();
    mret = 1'b1;
    step(1);
    mret = 1'b0;
    check("mret_in_handler", 32'(in_handler), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_interrupt"}, 32'(interrupt), 32'd0);
    check({tag, "_in_handler"}, 32'(in_handler), 32'd0);
    check({tag, "_mip"}, 32'(mip), 32'd0);
    check({tag, "_int_code"}, 32'(int_code), 32'd0);
    check({tag, "_mcause"}, mcause_val, 32'h8000_0000);
    check({tag, "_pc"}, pc_addr, 32'h0000_1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    irq_i    = '0;
    mie      = 16'hFFFF;
    MIE      = 1'b1;
    mtvec    = 32'h0000_1000;
    trap_ack = 1'b0;
    mret     = 1'b0;
    rst_n    = 1'b0;
    step(2);
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(1);

    // Level source 5, three-cycle latency, code held after the line drops.
    expect_req(5, 32'h0000_1000, 3);
    irq_i[5] = 1'b1;
    wait_req();
    irq_i[5] = 1'b0;
    step(3);
    check("hold_int", 32'(interrupt), 32'd1);
    check("hold_code", 32'(int_code), 32'd5);
    ack();
    step(3);
    check("no_nest", 32'(interrupt), 32'd0);
    do_mret();
    step(2);

    // Priority 3 over 9 in vectored mode; 9 follows after mret.
    mtvec = 32'h0000_1001;
    expect_req(3, 32'h0000_100C, 3);
    irq_i[3] = 1'b1;
    irq_i[9] = 1'b1;
    wait_req();
    ack();
    irq_i[3] = 1'b0;
    step(4);
    check("handler_no_req", 32'(interrupt), 32'd0);
    check("mip9_pending", 32'(mip[9]), 32'd1);
    check("mip3_dropped", 32'(mip[3]), 32'd0);
    expect_req(9, 32'h0000_1024, 2);
    do_mret();
    wait_req();
    irq_i[9] = 1'b0;
    ack();
    step(3);
    do_mret();
    step(1);

    // Vectored code 7, then wrap-around base with code 1.
    expect_req(7, 32'h0000_101C, 3);
    irq_i[7] = 1'b1;
    wait_req();
    irq_i[7] = 1'b0;
    ack();
    step(3);
    do_mret();
    step(1);
    mtvec = 32'hFFFF_FFFD;
    expect_req(1, 32'h0000_0000, 3);
    irq_i[1] = 1'b1;
    wait_req();
    irq_i[1] = 1'b0;
    ack();
    step(3);
    do_mret();
    step(1);

    // Edge source 2 latched while MIE=0; MIE=1 requests on the next edge.
    mtvec = 32'h0000_1000;
    MIE = 1'b0;
    irq_i[2] = 1'b1;
    step(1);
    irq_i[2] = 1'b0;
    step(4);
    check("gated_mie_int", 32'(interrupt), 32'd0);
    check("edge_held", 32'(mip[2]), 32'd1);
    expect_req(2, 32'h0000_1000, 1);
    MIE = 1'b1;
    wait_req();
    // New pulse reaches the pending logic on the same edge as trap_ack.
    irq_i[2] = 1'b1;
    step(1);
    irq_i[2] = 1'b0;
    ack();
    check("edge_set_wins", 32'(mip[2]), 32'd1);
    step(2);
    expect_req(2, 32'h0000_1000, 2);
    do_mret();
    wait_req();
    ack();
    check("edge_cleared", 32'(mip[2]), 32'd0);
    step(2);
    do_mret();
    step(1);

    // Per-source enable gating, then reset while in the handler.
    mie = 16'hFFEF;
    irq_i[4] = 1'b1;
    step(4);
    check("gated_mie4_int", 32'(interrupt), 32'd0);
    check("gated_mie4_mip", 32'(mip[4]), 32'd1);
    expect_req(4, 32'h0000_1000, 1);
    mie = 16'hFFFF;
    wait_req();
    ack();
    irq_i = '0;
    rst_n = 1'b0;
    step(1);
    check_reset_outputs("hreset");
    rst_n = 1'b1;
    step(4);
    check("post_idle", 32'(interrupt), 32'd0);
    check("sb_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl_v2.md
# int_ctrl_v2

Parametrised machine-mode interrupt controller for the core's CSR unit. Synchronises and latches up to 32 interrupt sources into a pending register (mip view) with per-source edge/level mode. Selects the highest-priority enabled pending source and raises a held trap request to the pipeline. Tracks handler occupancy until `mret` and supplies the trap PC and mcause value.

## Interface
Parameters:
- `NUM_IRQ`, 16, number of sources, 1..32.
- `EDGE_MASK`, `'0`, NUM_IRQ bits; bit i = 1 makes source i edge-triggered (rising), 0 makes it level.
- `CODE_W`, `$clog2(NUM_IRQ)` (minimum 1), derived width of the interrupt code; not overridden.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `irq_i` in NUM_IRQ: raw interrupt lines, already in the `clk` domain.
- `mie` in NUM_IRQ: per-source enable (CSR mie low bits).
- `MIE` in 1: global enable (mstatus.MIE).
- `mtvec` in 32: trap vector CSR; bit 0 = vectored mode.
- `trap_ack` in 1: core has taken the trap this cycle.
- `mret` in 1: handler return retired this cycle.
- `interrupt` out 1: trap request, held until `trap_ack`.
- `int_code` out CODE_W: code of the requested source, frozen while `interrupt` = 1.
- `pc_addr` out 32: trap target for `int_code`.
- `mcause_val` out 32: `{1'b1, zero-fill, int_code}`.
- `mip` out NUM_IRQ: pending register.
- `in_handler` out 1: a trap has been taken and `mret` has not yet been seen.

## Operation
- Sampling: `irq_q <= irq_i` every cycle.
- Pending bit, level source: `mip[i] <= irq_q[i]`.
- Pending bit, edge source:
  - Set when `irq_q[i]` = 1 and the previous sample was 0.
  - Cleared on `trap_ack` when i == `int_code`.
  - Set wins over clear in the same cycle.
- Eligibility: `elig = mip & mie`. Priority: lowest index wins (index 0 highest).
- States:
  - IDLE: if `MIE` and `|elig`, capture the priority-encoded code into `int_code` and go to REQ.
  - REQ: `interrupt` = 1 and `int_code` is frozen, even if the source deasserts or is disabled. `trap_ack` moves to HANDLER. `mret` is ignored.
  - HANDLER: `in_handler` = 1. `mret` moves to IDLE. No nesting; new pending bits accumulate but raise no request.
- `trap_ack` outside REQ is ignored. `mret` outside HANDLER is ignored.
- `pc_addr`:
  - `mtvec[0]` = 0 (direct): `{mtvec[31:2], 2'b00}`.
  - `mtvec[0]` = 1 (vectored): `{mtvec[31:2], 2'b00} + (int_code << 2)`, 32-bit add, wraps modulo 2^32.
- `mcause_val`: bit 31 = 1, bits [CODE_W-1:0] = `int_code`, all other bits 0.

## Timing
- Reset values: `irq_q`, `mip`, `int_code` = 0; state = IDLE; `interrupt` = 0; `in_handler` = 0.
  - `pc_addr` = `{mtvec[31:2], 2'b00}`, since it is combinational from `mtvec` and `int_code` = 0.
  - `mcause_val` = `32'h8000_0000`.
- Latency from a level `irq_i` rising (while enabled, `MIE` = 1, IDLE) to `interrupt` = 1 is 3 cycles:
  - edge N+1: `irq_q` set;
  - edge N+2: `mip` set;
  - edge N+3: `interrupt` asserted.
- `interrupt` falls on the clock edge that samples `trap_ack`; `in_handler` rises on the same edge.
- After `mret`, IDLE is re-entered on the next edge. A new request can appear one edge later.
- `rst_n` low mid-REQ or mid-HANDLER forces IDLE and clears all pending bits on that edge.

## Structure
- Shared package `int_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ, HANDLER} int_state_t`;
  - `MCAUSE_INT_BIT` = 31.
- One sub-module, `prio_enc #(N)`: combinational lowest-index-first encoder giving `code` and `valid`; instantiated once.
- Total RTL is roughly 150–200 lines.

## Test plan
- Level source: NUM_IRQ=16, `mie`=`16'hFFFF`, `MIE`=1, raise `irq_i[5]` → `interrupt`=1 exactly 3 cycles later, `int_code`=5, `mcause_val`=`32'h8000_0005`.
- Priority: raise `irq_i[3]` and `irq_i[9]` in the same cycle → `int_code`=3. After `trap_ack` then `mret` with `irq_i[9]` still high → second request with `int_code`=9.
- Edge source: EDGE_MASK bit 2 = 1, one-cycle pulse on `irq_i[2]` → `mip[2]` stays 1 until `trap_ack`. A new pulse landing on the `trap_ack` cycle leaves `mip[2]`=1.
- Vectored PC: `mtvec`=`32'h0000_1001`, code 7 → `pc_addr`=`32'h0000_101C`. `mtvec`=`32'hFFFF_FFFD`, code 1 → `pc_addr` wraps to `32'h0000_0000`.
- Gating: with `MIE`=0 or `mie[i]`=0 → no request, while `mip[i]` still shows pending. Setting `MIE`=1 → request on the next edge.
- Reset and hold: deassert `irq_i` while in REQ → `int_code` holds. `rst_n`=0 while in HANDLER → all outputs return to their reset values after one edge.
